// File: rtl/ibex_fp_register_file_mp_if.sv
// rtl/ibex_fp_register_file_mp_if.sv - read/write/claim bundle of the multi-port register file
interface ibex_fp_register_file_mp_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumWords     = 32,
  parameter int unsigned NumReadPorts = 3
);
  localparam int unsigned AddrW = $clog2(NumWords);

  // Read ports
  logic [NumReadPorts-1:0][AddrW-1:0]     raddr_i;
  logic [NumReadPorts-1:0][DataWidth-1:0] rdata_o;
  logic [NumReadPorts-1:0]                rbusy_o;

  // Write port A: single-cycle results
  logic                 we_a_i;
  logic [AddrW-1:0]     waddr_a_i;
  logic [DataWidth-1:0] wdata_a_i;

  // Write port B: multi-cycle FPU results, always releases the reservation
  logic                 we_b_i;
  logic [AddrW-1:0]     waddr_b_i;
  logic [DataWidth-1:0] wdata_b_i;

  // Destination reservation
  logic                 claim_req_i;
  logic [AddrW-1:0]     claim_addr_i;
  logic                 claim_gnt_o;

  // Registered error pulses
  logic                 collision_o;
  logic                 waw_err_o;

  // Register file side
  modport slave (
    input  raddr_i,
    output rdata_o,
    output rbusy_o,
    input  we_a_i,
    input  waddr_a_i,
    input  wdata_a_i,
    input  we_b_i,
    input  waddr_b_i,
    input  wdata_b_i,
    input  claim_req_i,
    input  claim_addr_i,
    output claim_gnt_o,
    output collision_o,
    output waw_err_o
  );

  // Pipeline (ID/WB) side
  modport master (
    output raddr_i,
    input  rdata_o,
    input  rbusy_o,
    output we_a_i,
    output waddr_a_i,
    output wdata_a_i,
    output we_b_i,
    output waddr_b_i,
    output wdata_b_i,
    output claim_req_i,
    output claim_addr_i,
    input  claim_gnt_o,
    input  collision_o,
    input  waw_err_o
  );
endinterface

// File: rtl/ibex_fp_register_file_mp.sv
// rtl/ibex_fp_register_file_mp.sv - multi-port FF register file with busy scoreboard (optional IBEX_RF_BYPASS_EN)
module ibex_fp_register_file_mp #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumWords     = 32,
  parameter int unsigned NumReadPorts = 3,
  parameter bit          ZeroReg      = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  ibex_fp_register_file_mp_if.slave  rf
);

  localparam int unsigned AddrW = $clog2(NumWords);

  // Storage and scoreboard
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [NumWords-1:0]  busy_q;
  logic [NumWords-1:0]  busy_d;
  logic                 collision_q, collision_d;
  logic                 waw_err_q, waw_err_d;

  // Decoded write/claim qualifiers
  logic zero_a, zero_b, zero_claim;
  logic same_addr;
  logic collide;
  logic we_a_eff, we_b_eff;
  logic a_busy;
  logic claim_gnt;
  logic claim_set;

  // Qualify writes and claims against register 0, busy bits and same-address collisions
  always_comb begin
    zero_a     = ZeroReg && (rf.waddr_a_i == '0);
    zero_b     = ZeroReg && (rf.waddr_b_i == '0);
    zero_claim = ZeroReg && (rf.claim_addr_i == '0);
    same_addr  = (rf.waddr_a_i == rf.waddr_b_i);
    a_busy     = busy_q[rf.waddr_a_i];

    // Both ports on the same (real) register: B wins, A is dropped
    collide    = rf.we_a_i && rf.we_b_i && same_addr && !zero_a;

    we_b_eff   = rf.we_b_i && !zero_b;
    we_a_eff   = rf.we_a_i && !zero_a && !a_busy && !collide;

    // A write into a reserved register is a WAW hazard; a collision already reports it
    collision_d = collide;
    waw_err_d   = rf.we_a_i && !zero_a && a_busy && !collide;

    // Grant uses the busy bits as they stand this cycle, so a same-cycle
    // port B release does not make the register claimable until next cycle
    claim_gnt  = rf.claim_req_i && !busy_q[rf.claim_addr_i];
    claim_set  = claim_gnt && !zero_claim;
  end

  assign rf.claim_gnt_o = claim_gnt;
  assign rf.collision_o = collision_q;
  assign rf.waw_err_o   = waw_err_q;

  // Next busy state: port B clears its target, a granted claim sets its target.
  // A grant only happens on a non-busy register, so when both hit the same
  // register the new reservation is kept rather than lost.
  always_comb begin
    busy_d = busy_q;
    if (we_b_eff) begin
      busy_d[rf.waddr_b_i] = 1'b0;
    end
    if (claim_set) begin
      busy_d[rf.claim_addr_i] = 1'b1;
    end
    if (ZeroReg) begin
      busy_d[0] = 1'b0;
    end
  end

  // Busy scoreboard and error pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      collision_q <= 1'b0;
      waw_err_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      collision_q <= collision_d;
      waw_err_q   <= waw_err_d;
    end
  end

  // Data storage; the qualifiers already keep register 0 untouched when it is hard-wired
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumWords); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we_a_eff) begin
        mem_q[rf.waddr_a_i] <= rf.wdata_a_i;
      end
      if (we_b_eff) begin
        mem_q[rf.waddr_b_i] <= rf.wdata_b_i;
      end
    end
  end

  // Combinational read ports, optionally forwarding same-cycle write data
  always_comb begin
    for (int p = 0; p < int'(NumReadPorts); p++) begin
      rf.rdata_o[p] = mem_q[rf.raddr_i[p]];
      rf.rbusy_o[p] = busy_q[rf.raddr_i[p]];
`ifdef IBEX_RF_BYPASS_EN
      // Port B is checked last so it overrides port A on the same address;
      // dropped A writes are excluded by we_a_eff
      if (we_a_eff && (rf.waddr_a_i == rf.raddr_i[p])) begin
        rf.rdata_o[p] = rf.wdata_a_i;
      end
      if (we_b_eff && (rf.waddr_b_i == rf.raddr_i[p])) begin
        rf.rdata_o[p] = rf.wdata_b_i;
        rf.rbusy_o[p] = 1'b0;
      end
`endif
      if (ZeroReg && (rf.raddr_i[p] == '0)) begin
        rf.rdata_o[p] = '0;
        rf.rbusy_o[p] = 1'b0;
      end
    end
  end

endmodule

// File: doc/ibex_fp_register_file_mp.md
# ibex_fp_register_file_mp

Multi-port, parametrised flip-flop register file for the integer and floating-point (F-extension) datapaths. It has a configurable number of read ports, two write ports and a per-register busy scoreboard. Port A takes single-cycle results (ALU, FP moves). Port B takes results from the multi-cycle FPU. The scoreboard lets the ID stage claim a destination register before issuing a long-latency FP operation and stall on RAW/WAW hazards. It replaces the single-write-port FF register file in the ID stage.

## Interface
- DataWidth, 32: register width in bits.
- NumWords, 32: number of registers (power of two, 2..32); AddrW = $clog2(NumWords).
- NumReadPorts, 3: read ports (1..4); 3 covers fused multiply-add rs1/rs2/rs3.
- ZeroReg, 1: 1 = register 0 hard-wired to 0 (integer file); 0 = register 0 is a real register (FP file).

- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- raddr_i  in  NumReadPorts×AddrW  read addresses.
- rdata_o  out  NumReadPorts×DataWidth  read data, combinational.
- rbusy_o  out  NumReadPorts  busy bit of each addressed register, combinational.
- we_a_i / waddr_a_i / wdata_a_i  in  1 / AddrW / DataWidth  write port A.
- we_b_i / waddr_b_i / wdata_b_i  in  1 / AddrW / DataWidth  write port B; always clears busy.
- claim_req_i  in  1  request to reserve claim_addr_i for a later port B write.
- claim_addr_i  in  AddrW  register to reserve.
- claim_gnt_o  out  1  claim accepted, combinational.
- collision_o  out  1  registered pulse: A and B wrote the same address in the previous cycle.
- waw_err_o  out  1  registered pulse: port A write to a busy register was dropped in the previous cycle.

## Operation
- Storage: NumWords×DataWidth flops; busy[NumWords-1:0] flops. If ZeroReg=1, register 0 has no data or busy flop, reads 0, and reads not busy.
- Port B write (we_b_i): store wdata_b_i and clear busy[waddr_b_i], whether or not busy was set.
- Port A write (we_a_i): store wdata_a_i only if busy[waddr_a_i]=0. If the register is busy, drop the write and set waw_err_o next cycle.
- Same-address collision (we_a_i & we_b_i & waddr_a_i==waddr_b_i): B wins, A is dropped, and collision_o is set next cycle. waw_err_o is not additionally raised.
- Writes to register 0 with ZeroReg=1 are ignored; no flags are raised.
- Claim: claim_gnt_o = claim_req_i & ~busy[claim_addr_i]. On grant, busy[claim_addr_i] is set next cycle.
  - Claim of register 0 with ZeroReg=1 is granted but sets nothing.
  - Claim and a port B write to the same address in the same cycle: the claim is not granted, because busy is still set in that cycle. The port B clear takes effect.
  - Claim granted and a port A write to the same address in the same cycle: the A write is performed, because busy was 0 in that cycle, and busy becomes 1.
- rbusy_o reflects the current busy flops, without bypass.

## Timing
- Write latency 1: data written on edge N is visible on rdata_o after edge N (unless bypass is enabled, see below).
- Busy set/clear latency 1 after the granting/writing edge.
- collision_o and waw_err_o are single-cycle pulses, one cycle after the event.
- Reset (asynchronous, at any time, including mid-claim or mid-write): all data flops 0, all busy 0, collision_o=0, waw_err_o=0. A pending claim is lost. Combinational outputs follow the reset state: rdata_o=0, rbusy_o=0, claim_gnt_o=claim_req_i.

## Configuration
- IBEX_RF_BYPASS_EN defined: each read port forwards same-cycle write data combinationally.
  - A matching, effective port B write has priority over port A.
  - rbusy_o for that port reads 0 if port B writes the address this cycle.
  - Dropped port A writes are never forwarded.
- IBEX_RF_BYPASS_EN undefined: reads return flop contents only; no forwarding logic is generated.

## Test plan
- Reset, then read all registers on every port -> rdata_o=0, rbusy_o=0; with ZeroReg=1, write 0xDEADBEEF to x0 -> x0 still reads 0.
- Claim f5 (gnt=1), then port A writes 0x11 to f5 -> waw_err_o=1 next cycle, f5 unchanged; port B writes 0x3F800000 -> f5=0x3F800000, busy cleared.
- Same cycle: A writes 0xAAAA to f7 and B writes 0xBBBB to f7 -> f7=0xBBBB, collision_o=1 for exactly one cycle.
- f9 busy; claim f9 and B writes f9 in the same cycle -> claim_gnt_o=0; the following cycle claim f9 -> gnt=1, busy=1.
- With IBEX_RF_BYPASS_EN: B writes 0x1234 to f3 while port 2 reads f3 -> rdata_o[2]=0x1234 in the same cycle, rbusy_o[2]=0. Without the macro -> old value.
- Assert rst_ni low for one cycle while f4 is busy and a claim is requested -> busy all 0, f4=0, pulse outputs 0 after release.
